// File: rtl/sb_pkg.sv
// Shared types for the system-bus peripheral arbiter: bus widths, master id
// and the read-return tag carried through the latency pipe.
package sb_pkg;
    localparam int SB_ADDR_W = 32;
    localparam int SB_DATA_W = 32;

    typedef logic sb_mid_t;

    typedef struct packed {
        logic    valid;
        sb_mid_t id;
    } sb_rtag_t;
endpackage

// File: rtl/sb_rtag_pipe.sv
// DEPTH-stage shift register of read tags; the last stage lines up with the
// slave's registered read data.
module sb_rtag_pipe
    import sb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic     clk_i,
    input  logic     rst,
    input  sb_rtag_t tag_in,
    output sb_rtag_t tag_out
);

    sb_rtag_t [DEPTH-1:0] stage;

    always_ff @(posedge clk_i) begin
        if (rst) begin
            stage <= '0;
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/sb_periph_arbiter.sv
// Two-master round-robin arbiter in front of one single-cycle peripheral slave,
// with a fixed-latency tag pipe routing read data back to the issuer.
module sb_periph_arbiter
    import sb_pkg::*;
#(
    parameter int READ_LAT = 1,
    parameter int ADDR_W   = SB_ADDR_W,
    parameter int DATA_W   = SB_DATA_W
) (
    input  logic                   clk_i,
    input  logic                   rst,
    input  logic [1:0]             m_req_i,
    input  logic [1:0]             m_we_i,
    input  logic [1:0][ADDR_W-1:0] m_addr_i,
    input  logic [1:0][DATA_W-1:0] m_wdata_i,
    output logic [1:0]             m_stall_o,
    output logic [1:0]             m_rvalid_o,
    output logic [DATA_W-1:0]      m_rdata_o,
    output logic                   s_req_o,
    output logic                   s_we_o,
    output logic [ADDR_W-1:0]      s_addr_o,
    output logic [DATA_W-1:0]      s_wdata_o,
    input  logic [DATA_W-1:0]      s_rdata_i
);

    logic       prio;
    logic [1:0] grant;
    sb_mid_t    gid;
    sb_rtag_t   tag_in;
    sb_rtag_t   tag_out;

    always_comb begin
        grant = 2'b00;
        gid   = prio;
        unique case (m_req_i)
            2'b01:   begin grant = 2'b01; gid = 1'b0; end
            2'b10:   begin grant = 2'b10; gid = 1'b1; end
            2'b11:   begin grant = prio ? 2'b10 : 2'b01; gid = prio; end
            default: ;
        endcase
    end

    assign s_req_o   = |grant;
    assign s_we_o    = m_we_i[gid];
    assign s_addr_o  = m_addr_i[gid];
    assign s_wdata_o = m_wdata_i[gid];
    assign m_stall_o = m_req_i & ~grant;

    // Pointer moves only on an accept, so a lone requester keeps winning.
    always_ff @(posedge clk_i) begin
        if (rst) begin
            prio <= 1'b0;
        end else if (s_req_o) begin
            prio <= ~gid;
        end
    end

    assign tag_in = '{valid: s_req_o & ~s_we_o, id: gid};

    sb_rtag_pipe #(.DEPTH(READ_LAT)) u_rtag_pipe (
        .clk_i   (clk_i),
        .rst     (rst),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    always_comb begin
        m_rvalid_o          = 2'b00;
        m_rvalid_o[tag_out.id] = tag_out.valid;
    end

    assign m_rdata_o = s_rdata_i;

endmodule

// File: tb/tb_sb_periph_arbiter.sv
// Scoreboard bench: two arbiters (READ_LAT 1 and 3) share one stimulus stream;
// a local grant/prio model predicts slave-side outputs and queues read returns.
module tb_sb_periph_arbiter;
    import sb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    typedef struct {
        int            due;
        logic          id;
        logic [DW-1:0] data;
    } rsp_t;

    logic                clk_i = 1'b0;
    logic                rst   = 1'b1;
    logic [1:0]          m_req = 2'b00;
    logic [1:0]          m_we  = 2'b00;
    logic [1:0][AW-1:0]  m_addr  = '0;
    logic [1:0][DW-1:0]  m_wdata = '0;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic logic [DW-1:0] init_word(input int k);
        return (k == 0) ? 32'h0000_00A5 : 32'h1000_0000 + 32'(k) * 32'h111;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s @cyc %0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int L = (g == 0) ? 1 : 3;
        logic [1:0]    stall, rvalid;
        logic [DW-1:0] rdata, s_wdata, s_rdata;
        logic          s_req, s_we;
        logic [AW-1:0] s_addr;
        logic [DW-1:0] mem [16];
        logic [DW-1:0] dl [L];
        rsp_t          q[$];

        sb_periph_arbiter #(.READ_LAT(L), .ADDR_W(AW), .DATA_W(DW)) dut (
            .clk_i(clk_i), .rst(rst),
            .m_req_i(m_req), .m_we_i(m_we), .m_addr_i(m_addr), .m_wdata_i(m_wdata),
            .m_stall_o(stall), .m_rvalid_o(rvalid), .m_rdata_o(rdata),
            .s_req_o(s_req), .s_we_o(s_we), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
            .s_rdata_i(s_rdata)
        );

        // Slave: word memory with an L-deep registered read path.
        always @(posedge clk_i) begin
            if (rst) begin
                for (int k = 0; k < 16; k++) mem[k] <= init_word(k);
            end else if (s_req && s_we) begin
                mem[s_addr[5:2]] <= s_wdata;
            end
            dl[0] <= (s_req && !s_we) ? mem[s_addr[5:2]] : 32'hDEAD_BEEF;
            for (int k = 1; k < L; k++) dl[k] <= dl[k-1];
        end
        assign s_rdata = dl[L-1];

        always @(negedge clk_i) begin
            if (q.size() > 0 && q[0].due == cyc) begin
                chk($sformatf("rvalid_L%0d", L), rvalid, q[0].id ? 2'b10 : 2'b01);
                chk($sformatf("rdata_L%0d", L), rdata, q[0].data);
                void'(q.pop_front());
            end else begin
                chk($sformatf("rvalid_idle_L%0d", L), rvalid, 2'b00);
            end
        end
    end

    // Bench-side model state
    txn_t          mq[2][$];
    txn_t          cur[2];
    logic          act[2] = '{1'b0, 1'b0};
    logic          prio_m = 1'b0;
    logic [DW-1:0] emem [16];
    logic          rnd = 1'b0;

    task automatic add(input int m, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        mq[m].push_back('{we: we, addr: a, wdata: d});
    endtask

    task automatic chk_inst(input string n, input logic [1:0] stall, input logic sreq, input logic swe,
                            input logic [AW-1:0] saddr, input logic [DW-1:0] swd,
                            input logic [1:0] es, input logic gr, input txn_t t);
        chk({"stall_", n}, stall, es);
        chk({"s_req_", n}, sreq, gr);
        if (gr) begin
            chk({"s_we_", n}, swe, t.we);
            chk({"s_addr_", n}, saddr, t.addr);
            if (t.we) chk({"s_wdata_", n}, swd, t.wdata);
        end
    endtask

    task automatic step(input logic r);
        logic [1:0] req, es;
        logic       gr, gid;
        rsp_t       rs;
        @(posedge clk_i);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (!act[i] && mq[i].size() > 0 && (!rnd || $urandom_range(3) != 0)) begin
                cur[i] = mq[i].pop_front();
                act[i] = 1'b1;
            end
        end
        rst = r;
        m_req = {act[1], act[0]};
        for (int i = 0; i < 2; i++) begin
            m_we[i]    = cur[i].we;
            m_addr[i]  = cur[i].addr;
            m_wdata[i] = cur[i].wdata;
        end
        req = m_req;
        gr  = |req;
        gid = (req == 2'b11) ? prio_m : req[1];
        es  = req & ~(gr ? (gid ? 2'b10 : 2'b01) : 2'b00);
        if (r) begin
            prio_m = 1'b0;
            for (int k = 0; k < 16; k++) emem[k] = init_word(k);
            while (gi[0].q.size() > 0 && gi[0].q[$].due > cyc) void'(gi[0].q.pop_back());
            while (gi[1].q.size() > 0 && gi[1].q[$].due > cyc) void'(gi[1].q.pop_back());
        end else if (gr) begin
            if (cur[gid].we) begin
                emem[cur[gid].addr[5:2]] = cur[gid].wdata;
            end else begin
                rs.id = gid; rs.data = emem[cur[gid].addr[5:2]];
                rs.due = cyc + 1; gi[0].q.push_back(rs);
                rs.due = cyc + 3; gi[1].q.push_back(rs);
            end
            prio_m = ~gid;
            act[gid] = 1'b0;
        end
        #3;
        chk_inst("L1", gi[0].stall, gi[0].s_req, gi[0].s_we, gi[0].s_addr, gi[0].s_wdata, es, gr, cur[gid]);
        chk_inst("L3", gi[1].stall, gi[1].s_req, gi[1].s_we, gi[1].s_addr, gi[1].s_wdata, es, gr, cur[gid]);
    endtask

    task automatic run();
        int n = 0;
        while ((mq[0].size() > 0 || mq[1].size() > 0 || act[0] || act[1]) && n < 400) begin
            step(1'b0);
            n++;
        end
        if (n >= 400) chk("drain_timeout", 1, 0);
        for (int k = 0; k < 4; k++) step(1'b0);
    endtask

    initial begin
        for (int k = 0; k < 16; k++) emem[k] = init_word(k);
        cur[0] = '0;
        cur[1] = '0;
        // Reset state, then a conflict seen while still in reset (m0 preferred)
        step(1'b1);
        step(1'b1);
        add(0, 1'b0, 32'h10, 32'h0);
        add(1, 1'b0, 32'h14, 32'h0);
        step(1'b1);
        run();
        // m0 alone reads 0x0 -> 0xA5
        add(0, 1'b0, 32'h0, 32'h0);
        run();
        // Continuous contention, alternating grants
        for (int k = 0; k < 4; k++) begin
            add(0, 1'b0, 32'(4 * k), 32'h0);
            add(1, 1'b0, 32'(4 * (k + 8)), 32'h0);
        end
        run();
        // Make prio=1, then m1 write 0x4<-1 vs m0 read 0x0, then read the write back
        add(0, 1'b0, 32'h8, 32'h0);
        run();
        add(1, 1'b1, 32'h4, 32'h1);
        add(0, 1'b0, 32'h0, 32'h0);
        run();
        add(0, 1'b0, 32'h4, 32'h0);
        run();
        // Lone m1 back-to-back reads, then a conflict m0 must win
        for (int k = 0; k < 3; k++) add(1, 1'b0, 32'(4 * (k + 1)), 32'h0);
        run();
        add(0, 1'b0, 32'h20, 32'h0);
        add(1, 1'b0, 32'h24, 32'h0);
        run();
        // Reset right after a read accept
        add(0, 1'b0, 32'hC, 32'h0);
        step(1'b0);
        step(1'b1);
        add(0, 1'b0, 32'h0, 32'h0);
        add(1, 1'b0, 32'h4, 32'h0);
        run();
        // Random traffic with idle gaps
        rnd = 1'b1;
        for (int k = 0; k < 40; k++) begin
            add(0, 1'($urandom_range(1)), 32'($urandom_range(15)) << 2, $urandom);
            add(1, 1'($urandom_range(1)), 32'($urandom_range(15)) << 2, $urandom);
        end
        run();
        if (gi[0].q.size() != 0 || gi[1].q.size() != 0) chk("rsp_left", 1, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sb_periph_arbiter.md
# sb_periph_arbiter

Two-master round-robin arbiter sharing one system-bus peripheral slave port (e.g. the LED controller) between the CPU load/store unit (master 0) and an auxiliary master such as a debug or DMA engine (master 1). Accepts at most one single-cycle transaction per clock. Stalls the losing master. Routes the slave's registered read data back to the issuing master after a fixed read latency.

## Interface
Parameters:
- READ_LAT, 1: slave read latency in cycles (1..4); read data valid READ_LAT cycles after acceptance.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.

Ports:
- clk_i  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- m_req_i  in  [1:0]  per-master request.
- m_we_i  in  [1:0]  per-master write enable.
- m_addr_i  in  2×ADDR_W  per-master address.
- m_wdata_i  in  2×DATA_W  per-master write data.
- m_stall_o  out  [1:0]  request not accepted this cycle; master holds request stable.
- m_rvalid_o  out  [1:0]  read data valid for that master.
- m_rdata_o  out  DATA_W  read data, shared by both masters; qualified by m_rvalid_o.
- s_req_o  out  1  slave request.
- s_we_o  out  1  slave write enable.
- s_addr_o  out  ADDR_W  slave address.
- s_wdata_o  out  DATA_W  slave write data.
- s_rdata_i  in  DATA_W  slave read data, registered inside the slave.

## Operation
- Grant is combinational from m_req_i and the priority pointer `prio` (1 bit).
  - One requester: it is granted.
  - Both request: master `prio` is granted.
  - Neither requests: no grant; s_req_o=0.
- The granted master's we/addr/wdata are muxed to the slave. s_req_o=1 for exactly the accepted transaction.
- m_stall_o[i] = m_req_i[i] & ~grant[i].
- prio update on any grant: prio <= ~granted_id. A master therefore never wins twice in a row while the other is waiting.
  - Idle cycles leave prio unchanged.
  - A lone requester may win on consecutive cycles.
- Read tag pipeline: READ_LAT stages of {valid, id}. Stage 0 loads {s_req_o & ~s_we_o, granted_id}.
- At the last stage: m_rvalid_o[id] = valid, and m_rdata_o = s_rdata_i.
- Writes complete at acceptance and produce no rvalid.
- Back-to-back reads from alternating masters are supported at full throughput. The pipeline never stalls.
- Address decoding is not performed here. All accepted requests go to the single slave.

## Timing
- Reset values: prio=0, all tag stages invalid. Therefore m_rvalid_o=0, m_stall_o follows m_req_i with master 0 preferred, and s_req_o follows requests.
- Request-to-slave latency: 0 cycles (combinational path).
- Read response latency: exactly READ_LAT cycles after the accept cycle. With READ_LAT=1 the response appears in the next cycle.
- Simultaneous cases:
  - A new accept and a returning response in the same cycle are independent.
  - A master may issue its next read in the cycle its previous response returns.
- Reset mid-operation: in-flight tags are cleared. Reads pending at reset never raise rvalid. prio returns to 0.
- A stalled master must keep req/we/addr/wdata stable until m_stall_o falls. Behaviour is undefined if it changes them.
- No combinational path exists from s_rdata_i to any slave-side output.

## Structure
- Package sb_pkg holds:
  - constants SB_ADDR_W=32 and SB_DATA_W=32;
  - typedef sb_mid_t (1-bit master id);
  - typedef packed struct sb_rtag_t {valid, id}.
- Sub-module sb_rtag_pipe implements the READ_LAT-deep tag shift register with synchronous clear.
- The top level contains the grant logic, prio register and muxes.

## Test plan
- Master 0 only, reads at 0x0 with slave returning 0x0000_00A5 → s_req_o same cycle, m_rvalid_o=2'b01 with m_rdata_o=0xA5 one cycle later, m_stall_o=0.
- Both masters request continuously starting from reset → grants alternate m0,m1,m0,…. Each master's stall is high on every other cycle. Throughput is 1 transaction/cycle.
- m1 writes 0x4←1 while m0 reads 0x0 in the same cycle, prio=1 → write accepted first with m0 stalled. The read is accepted next cycle. Only m0 gets rvalid, one cycle after its accept.
- Lone master 1 issues three consecutive reads → three accepts with no stall. m_rvalid_o=2'b10 on three consecutive cycles. prio=0 at the end.
- READ_LAT=3, alternating reads m0,m1 → rvalid pattern 01,10 exactly 3 cycles after the respective accepts.
- Assert rst the cycle after a read accept → no rvalid is produced, and the first post-reset conflict is granted to m0.
